multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB control FSM for a small
// MIPS subset (R-type add/sub/and/or/slt, addi, ori, lw, sw, j).
// Optional feature macro: MCU_BRANCH_EN adds beq (opcode 000100) as a
// FETCH-DECODE-EXEC sequence with a branch pulse in EXEC.
//
// Handshakes: an instruction transfers on a rising edge where
// instr_valid && instr_ready; instr_ready is high only in FETCH.
// mem_ready is a completion strobe that is sampled only in MEM.
module multicycle_control_unit #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              mem_ready,
  output logic              jump,
  output logic              branch,
  output logic [2:0]        alu_func,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   imm,
  output logic              signal_extension,
  output logic              ram_load,
  output logic              ram_write,
  output logic              reg_write,
  output logic [25:0]       jump_target,
  output logic              illegal,
  output logic              mem_timeout,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {OP_ALU, OP_LW, OP_SW, OP_J, OP_BEQ} op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Counter holds at most MEM_TIMEOUT-1 consecutive waits before aborting.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  op_t               r_op;
  op_t               w_dec_op;
  logic [31:0]       r_ir;
  logic [CW-1:0]     r_wait_cnt;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   w_dec_imm;
  logic [25:0]       r_jt;
  logic [2:0]        r_alu;
  logic [2:0]        w_dec_alu;
  logic              r_sext;
  logic              w_dec_sext;
  logic              w_dec_legal;
  logic              r_mem_timeout;
  logic              w_wait_hit;
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;

  assign w_opcode = r_ir[31:26];
  assign w_funct  = r_ir[5:0];

  // The MEM_TIMEOUT-th consecutive wait cycle aborts the access.
  assign w_wait_hit = (r_state == S_MEM) && !mem_ready &&
                      (r_wait_cnt == CW'(MEM_TIMEOUT - 1));

  // Instruction decode from the latched IR.
  always_comb begin
    w_dec_legal = 1'b1;
    w_dec_op    = OP_ALU;
    w_dec_alu   = ALU_ADD;
    w_dec_sext  = 1'b0;
    case (w_opcode)
      6'b000000: begin
        case (w_funct)
          6'b100000: w_dec_alu = ALU_ADD;
          6'b100010: w_dec_alu = ALU_SUB;
          6'b100100: w_dec_alu = ALU_AND;
          6'b100101: w_dec_alu = ALU_OR;
          6'b101010: w_dec_alu = ALU_SLT;
          default:   w_dec_legal = 1'b0;
        endcase
      end
      6'b001000: w_dec_sext = 1'b1;
      6'b001101: w_dec_alu  = ALU_OR;
      6'b100011: begin w_dec_op = OP_LW; w_dec_sext = 1'b1; end
      6'b101011: begin w_dec_op = OP_SW; w_dec_sext = 1'b1; end
      6'b000010: w_dec_op = OP_J;
`ifdef MCU_BRANCH_EN
      6'b000100: begin w_dec_op = OP_BEQ; w_dec_alu = ALU_SUB; w_dec_sext = 1'b1; end
`endif
      default:   w_dec_legal = 1'b0;
    endcase
    w_dec_imm = w_dec_sext ? {{(XLEN-16){r_ir[15]}}, r_ir[15:0]}
                           : XLEN'(r_ir[15:0]);
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = w_dec_legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        case (r_op)
          OP_ALU:       w_next = S_WB;
          OP_LW, OP_SW: w_next = S_MEM;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)       w_next = (r_op == OP_LW) ? S_WB : S_FETCH;
        else if (w_wait_hit) w_next = S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Instruction register loads only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst)                                  r_ir <= '0;
    else if (r_state == S_FETCH && instr_valid) r_ir <= instruction;
  end

  // Decoded fields are captured in DECODE and held until the next DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= OP_ALU;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
      r_imm  <= '0;
      r_jt   <= '0;
      r_alu  <= '0;
      r_sext <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_op   <= w_dec_op;
      r_rs   <= REG_AW'(r_ir[25:21]);
      r_rt   <= REG_AW'(r_ir[20:16]);
      r_rd   <= REG_AW'(r_ir[15:11]);
      r_imm  <= w_dec_imm;
      r_jt   <= r_ir[25:0];
      r_alu  <= w_dec_alu;
      r_sext <= w_dec_sext;
    end
  end

  // Consecutive MEM wait counter and the registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_mem_timeout <= w_wait_hit;
      if (r_state == S_MEM && !mem_ready && !w_wait_hit)
        r_wait_cnt <= r_wait_cnt + CW'(1);
      else
        r_wait_cnt <= '0;
    end
  end

  assign state            = r_state;
  assign instr_ready      = (r_state == S_FETCH);
  assign illegal          = (r_state == S_DECODE) && !w_dec_legal;
  assign jump             = (r_state == S_EXEC) && (r_op == OP_J);
`ifdef MCU_BRANCH_EN
  assign branch           = (r_state == S_EXEC) && (r_op == OP_BEQ);
`else
  assign branch           = 1'b0;
`endif
  assign ram_load         = (r_state == S_MEM) && (r_op == OP_LW);
  assign ram_write        = (r_state == S_MEM) && (r_op == OP_SW);
  assign reg_write        = (r_state == S_WB);
  assign mem_timeout      = r_mem_timeout;
  assign alu_func         = r_alu;
  assign rs               = r_rs;
  assign rt               = r_rt;
  assign rd               = r_rd;
  assign imm              = r_imm;
  assign signal_extension = r_sext;
  assign jump_target      = r_jt;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a vector table for the
// ALU-class and illegal decodes, plus hand sequences for MEM, jump,
// timeout, beq (MCU_BRANCH_EN) and reset-in-MEM.
module tb_multicycle_control_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] instruction;
  logic        instr_valid, instr_ready, mem_ready;
  logic        jump, branch;
  logic [2:0]  alu_func;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  logic        signal_extension, ram_load, ram_write, reg_write;
  logic [25:0] jump_target;
  logic        illegal, mem_timeout;
  logic [2:0]  state;

  multicycle_control_unit #(.XLEN(32), .REG_AW(5), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .jump(jump), .branch(branch),
    .alu_func(alu_func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .signal_extension(signal_extension), .ram_load(ram_load), .ram_write(ram_write),
    .reg_write(reg_write), .jump_target(jump_target), .illegal(illegal),
    .mem_timeout(mem_timeout), .state(state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Strobes must be mutually exclusive and silent in FETCH/DECODE.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(ram_load) + int'(ram_write) + int'(reg_write) + int'(jump) + int'(branch) > 1)
        viol++;
      if ((state == 3'd0 || state == 3'd1) &&
          (ram_load | ram_write | reg_write | jump | branch))
        viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction in FETCH; returns at the DECODE negedge.
  task automatic issue(input string name, input logic [31:0] ins);
    check({name, "_ready"}, instr_ready, 1);
    check({name, "_fetch"}, state, 0);
    instruction = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_regs"}, {rs, rt, rd, alu_func}, 0);
    check({name, "_imm"}, imm, 0);
    check({name, "_jt"}, jump_target, 0);
    check({name, "_strb"}, {ram_load, ram_write, reg_write, jump, branch,
                            illegal, mem_timeout, signal_extension}, 0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [2:0]  alu;
    logic        chk_imm;
    logic        sext;
    logic [31:0] imm;
    logic [4:0]  rs, rt, rd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cnt, bad_load, early_to, rw_seen;
    logic [2:0] e;

    tbl[0]  = '{32'h00221820, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        5'd1,  5'd2,  5'd3};
    tbl[1]  = '{32'h00853022, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0,        5'd4,  5'd5,  5'd6};
    tbl[2]  = '{32'h00E84824, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0,        5'd7,  5'd8,  5'd9};
    tbl[3]  = '{32'h03E0F825, 1'b0, 3'd3, 1'b0, 1'b0, 32'h0,        5'd31, 5'd0,  5'd31};
    tbl[4]  = '{32'h014B602A, 1'b0, 3'd4, 1'b0, 1'b0, 32'h0,        5'd10, 5'd11, 5'd12};
    tbl[5]  = '{32'h2001FFFF, 1'b0, 3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd0,  5'd1,  5'd31};
    tbl[6]  = '{32'h34248002, 1'b0, 3'd3, 1'b1, 1'b0, 32'h00008002, 5'd1,  5'd4,  5'd16};
    tbl[7]  = '{32'h20657FFF, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00007FFF, 5'd3,  5'd5,  5'd15};
    tbl[8]  = '{32'hFC000000, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0,        5'd0,  5'd0,  5'd0};
    tbl[9]  = '{32'h00221821, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0,        5'd0,  5'd0,  5'd0};
    tbl[10] = '{32'h24000000, 1'b1, 3'd0, 1'b0, 1'b0, 32'h0,        5'd0,  5'd0,  5'd0};

    // ---- reset ----
    rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; instruction = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_ready", instr_ready, 1);
    check_zero("rst");

    // ---- table: ALU-class and illegal decodes ----
    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      issue($sformatf("v%0d", i), v.instr);
      check($sformatf("v%0d_dec", i), state, 1);
      check($sformatf("v%0d_ill", i), illegal, v.ill);
      // Offered words outside FETCH must not reach the IR.
      instruction = $urandom();
      instr_valid = 1'b1;
      if (v.ill) begin
        step();
        check($sformatf("v%0d_ill_ret", i), state, 0);
        check($sformatf("v%0d_ill_off", i), illegal, 0);
      end else begin
        step();
        instruction = $urandom();
        check($sformatf("v%0d_exec", i), state, 2);
        check($sformatf("v%0d_alu", i), alu_func, v.alu);
        check($sformatf("v%0d_regs", i), {rs, rt, rd}, {v.rs, v.rt, v.rd});
        if (v.chk_imm) begin
          check($sformatf("v%0d_imm", i), imm, v.imm);
          check($sformatf("v%0d_sext", i), signal_extension, v.sext);
        end
        check($sformatf("v%0d_rw_exec", i), reg_write, 0);
        step();
        check($sformatf("v%0d_wb", i), state, 4);
        check($sformatf("v%0d_rw_wb", i), reg_write, 1);
        step();
        check($sformatf("v%0d_done", i), state, 0);
        check($sformatf("v%0d_rw_off", i), reg_write, 0);
      end
      instr_valid = 1'b0;
    end

    // ---- sw with 3 wait cycles; mem_ready high outside MEM is ignored ----
    mem_ready = 1'b1;
    issue("sw", 32'hAC240001);
    check("sw_dec", state, 1);
    step();
    check("sw_exec", state, 2);
    check("sw_regs", {rs, rt}, {5'd1, 5'd4});
    check("sw_imm", imm, 32'h1);
    check("sw_wr_exec", ram_write, 0);
    mem_ready = 1'b0;
    step();
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("sw_mem%0d", c), state, 3);
      check($sformatf("sw_wr%0d", c), ram_write, 1);
      check($sformatf("sw_ld%0d", c), ram_load, 0);
      if (c == 4) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    check("sw_done", state, 0);
    check("sw_wr_off", ram_write, 0);
    check("sw_rw", reg_write, 0);

    // ---- lw with immediate completion: EXEC, MEM, WB, FETCH ----
    mem_ready = 1'b1;
    issue("lw", 32'h8C438000);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd0);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check($sformatf("lw_state%0d", e), state, e);
      if (e == 3'd3) check("lw_load", ram_load, 1);
      if (e == 3'd4) check("lw_rw", reg_write, 1);
    end
    mem_ready = 1'b0;
    check("lw_imm", imm, 32'hFFFF8000);
    check("lw_sext", signal_extension, 1);
    check("lw_regs", {rs, rt}, {5'd2, 5'd3});

    // ---- lw timeout: mem_ready stays low ----
    issue("lwto", 32'h8C438000);
    step();
    check("lwto_exec", state, 2);
    step();
    cnt = 0; bad_load = 0; early_to = 0; rw_seen = 0;
    while (state == 3'd3 && cnt < 40) begin
      cnt++;
      if (!ram_load) bad_load++;
      if (mem_timeout) early_to++;
      if (reg_write) rw_seen++;
      step();
    end
    check("lwto_cycles", cnt, 15);
    check("lwto_load_held", bad_load, 0);
    check("lwto_early", early_to, 0);
    check("lwto_state", state, 0);
    check("lwto_pulse", mem_timeout, 1);
    check("lwto_load_off", ram_load, 0);
    step();
    check("lwto_pulse_off", mem_timeout, 0);
    check("lwto_idle", state, 0);
    check("lwto_rw", rw_seen + int'(reg_write), 0);

    // ---- j ----
    issue("j", 32'h08000003);
    check("j_dec_jump", jump, 0);
    step();
    check("j_exec", state, 2);
    check("j_jump", jump, 1);
    check("j_target", jump_target, 26'd3);
    step();
    check("j_done", state, 0);
    check("j_jump_off", jump, 0);

    // ---- beq ----
    issue("beq", 32'h1022FFFE);
`ifdef MCU_BRANCH_EN
    check("beq_ill", illegal, 0);
    step();
    check("beq_exec", state, 2);
    check("beq_branch", branch, 1);
    check("beq_alu", alu_func, 3'd1);
    check("beq_imm", imm, 32'hFFFFFFFE);
    step();
    check("beq_done", state, 0);
    check("beq_branch_off", branch, 0);
`else
    check("beq_ill", illegal, 1);
    check("beq_branch", branch, 0);
    step();
    check("beq_done", state, 0);
`endif

    // ---- reset while lw waits in MEM ----
    issue("lwrst", 32'h8C438000);
    step();
    step();
    check("lwrst_mem", state, 3);
    check("lwrst_load", ram_load, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("lwrst_state", state, 0);
    check("lwrst_ready", instr_ready, 1);
    check_zero("lwrst");
    step();
    check("lwrst_idle", state, 0);

    check("strobe_invariants", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
